// File: rtl/islip_voq_scheduler_pkg.sv
// Shared definitions for the iSLIP VOQ scheduler: default port count and FSM state encoding.
package islip_voq_scheduler_pkg;

   localparam int unsigned PORT_NUB_TOTAL = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCHED = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/islip_voq_scheduler_arb.sv
// Round-robin priority arbiter: picks the first request at or after ptr_i, wrapping modulo N.
// Purely combinational; the request vector is doubled so a linear scan covers the wrap.
module rr_prio_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned W  = $clog2(N),
   localparam int unsigned PW = $clog2(2 * N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   logic [2*N-1:0] dbl;
   logic [PW-1:0]  pos;
   logic [W-1:0]   sel;

   always_comb begin
      dbl   = {req_i, req_i};
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = '0;
      sel   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = PW'(ptr_i) + PW'(k);
         if (!any_o && dbl[pos]) begin
            any_o      = 1'b1;
            sel        = (pos >= PW'(N)) ? W'(pos - PW'(N)) : W'(pos);
            idx_o      = sel;
            gnt_o[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/islip_voq_scheduler.sv
// Single-iteration iSLIP scheduler: one grant/accept round per cell slot driving VOQ pops,
// crossbar selects and output writes. Define ISLIP_STATS_EN to add match/starvation statistics.
module islip_voq_scheduler
   import islip_voq_scheduler_pkg::*;
#(
   parameter  int unsigned PORT_NUB    = PORT_NUB_TOTAL,
   parameter  int unsigned SLOT_CYCLES = 4,
   localparam int unsigned WIDTH_SEL   = $clog2(PORT_NUB)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              en,
   input  logic [PORT_NUB*PORT_NUB-1:0]      empty_in,
   input  logic [PORT_NUB-1:0]               full_in,
   output logic [PORT_NUB-1:0]               rd_out,
   output logic [PORT_NUB*WIDTH_SEL-1:0]     rd_sel,
   output logic [PORT_NUB*WIDTH_SEL-1:0]     mux_sel,
   output logic [PORT_NUB-1:0]               wr_out,
   output logic                              slot_start
`ifdef ISLIP_STATS_EN
   ,
   output logic [WIDTH_SEL:0]                match_cnt,
   output logic [31:0]                       total_cnt,
   output logic [PORT_NUB-1:0]               starve_flag
`endif
);

   localparam int unsigned N  = PORT_NUB;
   localparam int unsigned CW = $clog2(SLOT_CYCLES);

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [N-1:0][WIDTH_SEL-1:0]   g_ptr_q, g_ptr_d;
   logic [N-1:0][WIDTH_SEL-1:0]   a_ptr_q, a_ptr_d;
   logic [N-1:0][WIDTH_SEL-1:0]   rd_sel_q, rd_sel_d;
   logic [N-1:0][WIDTH_SEL-1:0]   mux_sel_q, mux_sel_d;
   logic [N-1:0]                  rd_q, rd_d;
   logic [N-1:0]                  wr_q, wr_d;
   logic [N-1:0]                  pend_wr_q, pend_wr_d;
   logic                          slot_q, slot_d;

   logic [N-1:0][N-1:0]           empty_m;
   logic [N-1:0][N-1:0]           req_by_dst;
   logic [N-1:0][N-1:0]           gnt_oh;
   logic [N-1:0][WIDTH_SEL-1:0]   g_idx;
   logic [N-1:0]                  g_any;
   logic [N-1:0][N-1:0]           acc_req;
   logic [N-1:0][N-1:0]           acc_oh;
   logic [N-1:0][WIDTH_SEL-1:0]   a_idx;
   logic [N-1:0]                  a_any;
   logic [N-1:0]                  dst_match;

   function automatic logic [WIDTH_SEL-1:0] ptr_inc(input logic [WIDTH_SEL-1:0] p);
      return (32'(p) == N - 1) ? '0 : p + 1'b1;
   endfunction

   assign empty_m = empty_in;

   // req_by_dst[d][s]: request seen by output d; acc_req[s][d]: grant seen by input s.
   always_comb begin
      req_by_dst = '0;
      acc_req    = '0;
      dst_match  = '0;
      for (int unsigned s = 0; s < N; s++) begin
         for (int unsigned d = 0; d < N; d++) begin
            req_by_dst[d][s] = ~empty_m[s][d] & ~full_in[d];
            acc_req[s][d]    = gnt_oh[d][s];
         end
      end
      for (int unsigned d = 0; d < N; d++) begin
         dst_match[d] = g_any[d] & acc_oh[g_idx[d]][d];
      end
   end

   for (genvar d = 0; d < N; d++) begin : g_grant
      rr_prio_arbiter #(.N(N)) u_grant (
         .req_i (req_by_dst[d]),
         .ptr_i (g_ptr_q[d]),
         .gnt_o (gnt_oh[d]),
         .idx_o (g_idx[d]),
         .any_o (g_any[d])
      );
   end

   for (genvar s = 0; s < N; s++) begin : g_accept
      rr_prio_arbiter #(.N(N)) u_accept (
         .req_i (acc_req[s]),
         .ptr_i (a_ptr_q[s]),
         .gnt_o (acc_oh[s]),
         .idx_o (a_idx[s]),
         .any_o (a_any[s])
      );
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      g_ptr_d   = g_ptr_q;
      a_ptr_d   = a_ptr_q;
      rd_sel_d  = rd_sel_q;
      mux_sel_d = mux_sel_q;
      pend_wr_d = pend_wr_q;
      rd_d      = '0;
      slot_d    = 1'b0;
      // write follows the pop by one cycle to match the VOQ read latency
      wr_d      = slot_q ? pend_wr_q : '0;
      unique case (state_q)
         IDLE: if (en) state_d = SCHED;
         SCHED: begin
            state_d   = HOLD;
            cnt_d     = '0;
            slot_d    = 1'b1;
            rd_d      = a_any;
            pend_wr_d = dst_match;
            for (int unsigned s = 0; s < N; s++) begin
               if (a_any[s]) begin
                  rd_sel_d[s] = a_idx[s];
                  a_ptr_d[s]  = ptr_inc(a_idx[s]);
               end
            end
            for (int unsigned d = 0; d < N; d++) begin
               if (dst_match[d]) begin
                  mux_sel_d[d] = g_idx[d];
                  g_ptr_d[d]   = ptr_inc(g_idx[d]);
               end
            end
         end
         HOLD: begin
            if (cnt_q == CW'(SLOT_CYCLES - 2)) state_d = en ? SCHED : IDLE;
            else                               cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         g_ptr_q   <= '0;
         a_ptr_q   <= '0;
         rd_sel_q  <= '0;
         mux_sel_q <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         pend_wr_q <= '0;
         slot_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         g_ptr_q   <= g_ptr_d;
         a_ptr_q   <= a_ptr_d;
         rd_sel_q  <= rd_sel_d;
         mux_sel_q <= mux_sel_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         pend_wr_q <= pend_wr_d;
         slot_q    <= slot_d;
      end
   end

   assign rd_out     = rd_q;
   assign rd_sel     = rd_sel_q;
   assign mux_sel    = mux_sel_q;
   assign wr_out     = wr_q;
   assign slot_start = slot_q;

`ifdef ISLIP_STATS_EN
   localparam int unsigned SW = $clog2(2 * N + 1);

   logic [WIDTH_SEL:0]        match_cnt_q, match_cnt_d, pop;
   logic [31:0]               total_cnt_q, total_cnt_d;
   logic [N-1:0][SW-1:0]      starve_cnt_q, starve_cnt_d;
   logic [N-1:0]              starve_q, starve_d;
   logic [N-1:0]              demand;

   // demand counts occupancy regardless of back-pressure, so a full output can starve
   always_comb begin
      match_cnt_d  = match_cnt_q;
      total_cnt_d  = total_cnt_q;
      starve_cnt_d = starve_cnt_q;
      starve_d     = starve_q;
      pop          = '0;
      demand       = '0;
      for (int unsigned s = 0; s < N; s++) begin
         pop = pop + (WIDTH_SEL + 1)'(a_any[s]);
         for (int unsigned d = 0; d < N; d++) demand[d] = demand[d] | ~empty_m[s][d];
      end
      if (state_q == SCHED) begin
         match_cnt_d = pop;
         total_cnt_d = total_cnt_q + 32'(pop);
         for (int unsigned d = 0; d < N; d++) begin
            if (demand[d] && !dst_match[d]) begin
               if (starve_cnt_q[d] == SW'(2 * N - 1)) starve_d[d] = 1'b1;
               if (starve_cnt_q[d] != SW'(2 * N))     starve_cnt_d[d] = starve_cnt_q[d] + 1'b1;
            end else begin
               starve_cnt_d[d] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt_q  <= '0;
         total_cnt_q  <= '0;
         starve_cnt_q <= '0;
         starve_q     <= '0;
      end else begin
         match_cnt_q  <= match_cnt_d;
         total_cnt_q  <= total_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         starve_q     <= starve_d;
      end
   end

   assign match_cnt   = match_cnt_q;
   assign total_cnt   = total_cnt_q;
   assign starve_flag = starve_q;
`endif

endmodule

// File: tb/tb_islip_voq_scheduler.sv
// Directed bench for islip_voq_scheduler (PORT_NUB=4, SLOT_CYCLES=4) with hand-derived expectations.
module tb_islip_voq_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] empty_in;
   logic [3:0]  full_in;
   logic [3:0]  rd_out;
   logic [7:0]  rd_sel;
   logic [7:0]  mux_sel;
   logic [3:0]  wr_out;
   logic        slot_start;
`ifdef ISLIP_STATS_EN
   logic [2:0]  match_cnt;
   logic [31:0] total_cnt;
   logic [3:0]  starve_flag;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   islip_voq_scheduler #(.PORT_NUB(4), .SLOT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .empty_in   (empty_in),
      .full_in    (full_in),
      .rd_out     (rd_out),
      .rd_sel     (rd_sel),
      .mux_sel    (mux_sel),
      .wr_out     (wr_out),
      .slot_start (slot_start)
`ifdef ISLIP_STATS_EN
      ,
      .match_cnt  (match_cnt),
      .total_cnt  (total_cnt),
      .starve_flag(starve_flag)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns at the falling edge of the first cycle of the next slot (or after a bounded wait).
   task automatic wait_slot(input string tag);
      int n = 0;
      @(negedge clk);
      while (slot_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_slot"}, 32'(slot_start), 32'd1);
   endtask

   task automatic slot_check(input string tag, input logic [3:0] e_rd, input logic [7:0] e_rdsel,
                             input logic [7:0] e_mux, input logic [3:0] e_wr);
      wait_slot(tag);
      check({tag, "_rd"},    32'(rd_out),  32'(e_rd));
      check({tag, "_rdsel"}, 32'(rd_sel),  32'(e_rdsel));
      check({tag, "_mux"},   32'(mux_sel), 32'(e_mux));
      @(negedge clk);
      check({tag, "_wr"},    32'(wr_out),  32'(e_wr));
      check({tag, "_rd1"},   32'(rd_out),  32'd0);
   endtask

   initial begin
      int act;
      rst_n    = 1'b0;
      en       = 1'b0;
      empty_in = 16'hFFFF;
      full_in  = 4'h0;
      repeat (2) @(negedge clk);
      check("rst_rd",    32'(rd_out),     32'd0);
      check("rst_wr",    32'(wr_out),     32'd0);
      check("rst_rdsel", 32'(rd_sel),     32'd0);
      check("rst_mux",   32'(mux_sel),    32'd0);
      check("rst_slot",  32'(slot_start), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_slot", 32'(slot_start), 32'd0);

      // single VOQ 2->1
      empty_in = 16'hFDFF;
      en       = 1'b1;
      slot_check("t1a", 4'h4, 8'h10, 8'h08, 4'h2);
      slot_check("t1b", 4'h4, 8'h10, 8'h08, 4'h2);

      // VOQ 0->0 and 3->0 contend for output 0
      empty_in = 16'hEFFE;
      slot_check("t2a", 4'h1, 8'h10, 8'h08, 4'h1);
      slot_check("t2b", 4'h8, 8'h10, 8'h0B, 4'h1);
      slot_check("t2c", 4'h1, 8'h10, 8'h08, 4'h1);
      slot_check("t2d", 4'h8, 8'h10, 8'h0B, 4'h1);

      // all VOQs occupied: pointers desynchronise into full permutations
      empty_in = 16'h0000;
      slot_check("t3a", 4'h9, 8'h52, 8'h0F, 4'h6);
      slot_check("t3b", 4'h3, 8'h5B, 8'h1F, 4'hC);
      slot_check("t3c", 4'h7, 8'h6C, 8'h6C, 4'hD);
      slot_check("t3d", 4'hF, 8'hB1, 8'hB1, 4'hF);
`ifdef ISLIP_STATS_EN
      check("t3d_match", 32'(match_cnt), 32'd4);
      check("t3d_total", total_cnt,      32'd17);
`endif
      slot_check("t3e", 4'hF, 8'hC6, 8'hC6, 4'hF);

      // output 1 back-pressured, then released
      empty_in = 16'hFDFF;
      full_in  = 4'b0010;
      slot_check("t4blk", 4'h0, 8'hC6, 8'hC6, 4'h0);
      full_in  = 4'b0000;
      slot_check("t4rel", 4'h4, 8'hD6, 8'hCA, 4'h2);

      // enable dropped in the first HOLD cycle
      wait_slot("t5");
      check("t5_rd", 32'(rd_out), 32'h4);
      en = 1'b0;
      @(negedge clk);
      check("t5_wr", 32'(wr_out), 32'h2);
      act = 0;
      repeat (12) begin
         @(negedge clk);
         if (slot_start !== 1'b0 || rd_out !== 4'h0 || wr_out !== 4'h0) act++;
      end
      check("t5_idle", 32'(act), 32'd0);

      // asynchronous reset in the middle of a slot
      en = 1'b1;
      wait_slot("t6");
      check("t6_rd", 32'(rd_out), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_rd",    32'(rd_out),     32'd0);
      check("t6_rst_slot",  32'(slot_start), 32'd0);
      check("t6_rst_rdsel", 32'(rd_sel),     32'd0);
      check("t6_rst_mux",   32'(mux_sel),    32'd0);
      @(negedge clk);
      check("t6_nowr", 32'(wr_out), 32'd0);
      en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

`ifdef ISLIP_STATS_EN
      check("t7_total0", total_cnt, 32'd0);
      empty_in = 16'hFFFE;
      full_in  = 4'b0001;
      en       = 1'b1;
      repeat (7) wait_slot("t7");
      check("t7_starve7", 32'(starve_flag), 32'd0);
      check("t7_match",   32'(match_cnt),   32'd0);
      wait_slot("t7");
      check("t7_starve8", 32'(starve_flag), 32'd1);
      en = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
